// File: rtl/fb_draw_writer.sv
// fb_draw_writer: write-side drawing engine for the 24-bit framebuffer RAM.
// Turns PIXEL / FILL / CLEAR commands into one RAM write per clock.
// The framebuffer is row-major, so address = y*FB_W + x.
// Optional build macro FB_DRAW_CLIP_EN: out-of-range coordinates are
// clamped (FILL) or dropped (PIXEL) instead of raising cmd_err.
module fb_draw_writer #(
  parameter int unsigned FB_W   = 280,
  parameter int unsigned FB_H   = 192,
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [8:0]        cmd_x0,
  input  logic [7:0]        cmd_y0,
  input  logic [8:0]        cmd_x1,
  input  logic [7:0]        cmd_y1,
  input  logic [DATA_W-1:0] cmd_color,
  output logic [ADDR_W-1:0] fb_adr_w,
  output logic [DATA_W-1:0] fb_d,
  output logic              fb_we,
  output logic              fb_w_clk,
  output logic              busy,
  output logic              cmd_err
);

  localparam int unsigned X_W = 9;
  localparam int unsigned Y_W = 8;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_PIXEL = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [X_W-1:0]    X_LAST   = X_W'(FB_W - 1);
  localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(FB_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_cmd_ready;
  logic                r_busy;
  logic                r_cmd_err;
  logic                r_fb_we;
  logic [ADDR_W-1:0]   r_fb_adr_w;
  logic [DATA_W-1:0]   r_fb_d;

  // Command fields captured at acceptance
  logic [1:0]          r_op;
  logic [X_W-1:0]      r_x0;
  logic [Y_W-1:0]      r_y0;
  logic [X_W-1:0]      r_x1;
  logic [Y_W-1:0]      r_y1;
  logic [DATA_W-1:0]   r_color;

  // Scan state
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [X_W-1:0]      r_x_lo;
  logic [X_W-1:0]      r_x_hi;
  logic [Y_W-1:0]      r_y_hi;
  logic [ADDR_W-1:0]   r_row_base;

  // Setup-stage combinational results
  logic [X_W-1:0]      w_xlo_ord;
  logic [X_W-1:0]      w_xhi_ord;
  logic [Y_W-1:0]      w_ylo_ord;
  logic [Y_W-1:0]      w_yhi_ord;
  logic [X_W-1:0]      w_xlo;
  logic [X_W-1:0]      w_xhi;
  logic [Y_W-1:0]      w_ylo;
  logic [Y_W-1:0]      w_yhi;
  logic                w_oob;
  logic                w_err;
  logic                w_drop;
  logic [ADDR_W-1:0]   w_row_base;
  logic [ADDR_W-1:0]   w_first_adr;
  logic                w_last_x;
  logic                w_last_y;

  assign fb_w_clk  = CLOCK_50;
  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign cmd_err   = r_cmd_err;
  assign fb_we     = r_fb_we;
  assign fb_adr_w  = r_fb_adr_w;
  assign fb_d      = r_fb_d;

  assign w_last_x = (r_x == r_x_hi);
  assign w_last_y = (r_y == r_y_hi);

  // Order corners, range-check or clamp, and compute the first row base
  always_comb begin
    w_xlo_ord = r_x0;
    w_xhi_ord = r_x0;
    w_ylo_ord = r_y0;
    w_yhi_ord = r_y0;
    w_err     = 1'b0;
    w_drop    = 1'b0;

    case (r_op)
      OP_CLEAR: begin
        w_xlo_ord = '0;
        w_xhi_ord = X_LAST;
        w_ylo_ord = '0;
        w_yhi_ord = Y_LAST;
      end
      OP_FILL: begin
        w_xlo_ord = (r_x1 < r_x0) ? r_x1 : r_x0;
        w_xhi_ord = (r_x1 < r_x0) ? r_x0 : r_x1;
        w_ylo_ord = (r_y1 < r_y0) ? r_y1 : r_y0;
        w_yhi_ord = (r_y1 < r_y0) ? r_y0 : r_y1;
      end
      default: begin
        w_xlo_ord = r_x0;
        w_xhi_ord = r_x0;
        w_ylo_ord = r_y0;
        w_yhi_ord = r_y0;
      end
    endcase

    // After ordering only the high corner can exceed the frame
    w_oob = (w_xhi_ord > X_LAST) || (w_yhi_ord > Y_LAST);

    w_xlo = w_xlo_ord;
    w_xhi = w_xhi_ord;
    w_ylo = w_ylo_ord;
    w_yhi = w_yhi_ord;

`ifdef FB_DRAW_CLIP_EN
    if (w_xlo_ord > X_LAST) w_xlo = X_LAST;
    if (w_xhi_ord > X_LAST) w_xhi = X_LAST;
    if (w_ylo_ord > Y_LAST) w_ylo = Y_LAST;
    if (w_yhi_ord > Y_LAST) w_yhi = Y_LAST;
    w_drop = (r_op == OP_PIXEL) && w_oob;
`else
    w_err  = ((r_op == OP_PIXEL) || (r_op == OP_FILL)) && w_oob;
`endif

    w_row_base  = ADDR_W'(w_ylo) * ROW_STEP;
    w_first_adr = w_row_base + ADDR_W'(w_xlo);
  end

  // Command FSM with registered handshake and RAM write port
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_fb_we     <= 1'b0;
      r_fb_adr_w  <= '0;
      r_fb_d      <= '0;
      r_op        <= OP_NOP;
      r_x0        <= '0;
      r_y0        <= '0;
      r_x1        <= '0;
      r_y1        <= '0;
      r_color     <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_x_lo      <= '0;
      r_x_hi      <= '0;
      r_y_hi      <= '0;
      r_row_base  <= '0;
    end else begin
      r_cmd_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_op        <= cmd_op;
            r_x0        <= cmd_x0;
            r_y0        <= cmd_y0;
            r_x1        <= cmd_x1;
            r_y1        <= cmd_y1;
            r_color     <= cmd_color;
            r_state     <= S_SETUP;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end

        S_SETUP: begin
          if ((r_op == OP_NOP) || w_err || w_drop) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_cmd_err   <= w_err;
          end else begin
            r_state    <= S_WRITE;
            r_fb_we    <= 1'b1;
            r_fb_adr_w <= w_first_adr;
            r_fb_d     <= r_color;
            r_x        <= w_xlo;
            r_y        <= w_ylo;
            r_x_lo     <= w_xlo;
            r_x_hi     <= w_xhi;
            r_y_hi     <= w_yhi;
            r_row_base <= w_row_base;
          end
        end

        S_WRITE: begin
          if (w_last_x && w_last_y) begin
            r_state     <= S_IDLE;
            r_fb_we     <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end else if (w_last_x) begin
            r_x        <= r_x_lo;
            r_y        <= r_y + Y_W'(1);
            r_row_base <= r_row_base + ROW_STEP;
            r_fb_adr_w <= r_row_base + ROW_STEP + ADDR_W'(r_x_lo);
          end else begin
            r_x        <= r_x + X_W'(1);
            r_fb_adr_w <= r_fb_adr_w + ADDR_W'(1);
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_fb_we     <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_draw_writer.sv
// Directed testbench for fb_draw_writer (default 280x192 framebuffer).
module tb_fb_draw_writer;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [8:0]  cmd_x0;
  logic [7:0]  cmd_y0;
  logic [8:0]  cmd_x1;
  logic [7:0]  cmd_y1;
  logic [23:0] cmd_color;
  logic [15:0] fb_adr_w;
  logic [23:0] fb_d;
  logic        fb_we;
  logic        fb_w_clk;
  logic        busy;
  logic        cmd_err;

  int n_vec = 0;
  int n_err = 0;

  int unsigned cap_adr[$];
  logic [23:0] cap_d[$];
  int          cap_errs;
  int          cap_busy_low;

  fb_draw_writer dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_x1    (cmd_x1),
    .cmd_y1    (cmd_y1),
    .cmd_color (cmd_color),
    .fb_adr_w  (fb_adr_w),
    .fb_d      (fb_d),
    .fb_we     (fb_we),
    .fb_w_clk  (fb_w_clk),
    .busy      (busy),
    .cmd_err   (cmd_err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Present a command at a falling edge and hold it until accepted
  task automatic send(input logic [1:0] op, input logic [8:0] x0, input logic [7:0] y0,
                      input logic [8:0] x1, input logic [7:0] y1, input logic [23:0] color);
    bit ok;
    @(negedge CLOCK_50);
    cmd_op = op; cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1; cmd_color = color;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge CLOCK_50);
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL send_ready_timeout: cmd_ready got 0 want 1");
    end
    @(posedge CLOCK_50);
    #1 cmd_valid = 1'b0;
  endtask

  // Record writes and cmd_err pulses until the engine is ready again
  task automatic collect(input int budget);
    bit done;
    cap_adr.delete(); cap_d.delete();
    cap_errs = 0; cap_busy_low = 0; done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLOCK_50);
      if (fb_we) begin cap_adr.push_back(int'(fb_adr_w)); cap_d.push_back(fb_d); end
      if (cmd_err) cap_errs++;
      if (cmd_ready) begin done = 1'b1; break; end
      if (!busy) cap_busy_low++;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL collect_timeout: cmd_ready got 0 want 1 after %0d cycles", budget);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00;
    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_color = '0;
    repeat (3) @(negedge CLOCK_50);
    n_vec++;
    if ({fb_we, cmd_err, busy, cmd_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_ctrl: we/err/busy/ready got %b want 0001", {fb_we, cmd_err, busy, cmd_ready});
    end
    n_vec++;
    if (fb_adr_w !== 16'd0 || fb_d !== 24'd0) begin
      n_err++;
      $display("FAIL reset_data: adr/d got %0d/%h want 0/000000", fb_adr_w, fb_d);
    end
    reset = 1'b1;
  endtask

  task automatic test_pixel;
    send(2'b01, 9'd5, 8'd2, 9'd0, 8'd0, 24'hFF0000);
    @(negedge CLOCK_50);
    n_vec++;
    if ({fb_we, busy, cmd_ready} !== 3'b010) begin
      n_err++;
      $display("FAIL pixel_setup: we/busy/ready got %b want 010", {fb_we, busy, cmd_ready});
    end
    @(negedge CLOCK_50);
    n_vec++;
    if (fb_we !== 1'b1 || fb_adr_w !== 16'd565 || fb_d !== 24'hFF0000) begin
      n_err++;
      $display("FAIL pixel_write: we/adr/d got %b/%0d/%h want 1/565/ff0000", fb_we, fb_adr_w, fb_d);
    end
    @(negedge CLOCK_50);
    n_vec++;
    if ({fb_we, busy, cmd_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL pixel_done: we/busy/ready got %b want 001", {fb_we, busy, cmd_ready});
    end
  endtask

  task automatic test_fill;
    int unsigned exp_a[6] = '{850, 851, 852, 1130, 1131, 1132};
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) send(2'b10, 9'd10, 8'd3, 9'd12, 8'd4, 24'h00FF00);
      else           send(2'b10, 9'd12, 8'd4, 9'd10, 8'd3, 24'h00FF00);
      collect(100);
      n_vec++;
      if (cap_adr.size() != 6) begin
        n_err++;
        $display("FAIL fill_count pass %0d: got %0d want 6", pass, cap_adr.size());
      end else begin
        for (int i = 0; i < 6; i++) begin
          n_vec++;
          if (cap_adr[i] != exp_a[i] || cap_d[i] !== 24'h00FF00) begin
            n_err++;
            $display("FAIL fill_word pass %0d #%0d: adr/d got %0d/%h want %0d/00ff00",
                     pass, i, cap_adr[i], cap_d[i], exp_a[i]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int bad;
    send(2'b11, 9'd100, 8'd100, 9'd0, 8'd0, 24'h000000);
    // Next command presented while busy and held
    cmd_op = 2'b01; cmd_x0 = 9'd7; cmd_y0 = 8'd10; cmd_color = 24'hABCDEF;
    cmd_valid = 1'b1;
    collect(60000);
    @(posedge CLOCK_50);
    #1 cmd_valid = 1'b0;
    n_vec++;
    if (cap_adr.size() != 53760) begin
      n_err++;
      $display("FAIL clear_count: got %0d want 53760", cap_adr.size());
    end else begin
      bad = -1;
      for (int i = 0; i < 53760; i++)
        if (cap_adr[i] != i || cap_d[i] !== 24'h000000) begin bad = i; break; end
      n_vec++;
      if (bad >= 0) begin
        n_err++;
        $display("FAIL clear_seq #%0d: adr/d got %0d/%h want %0d/000000", bad, cap_adr[bad], cap_d[bad], bad);
      end
    end
    n_vec++;
    if (cap_busy_low != 0) begin
      n_err++;
      $display("FAIL clear_busy: low cycles got %0d want 0", cap_busy_low);
    end
    @(negedge CLOCK_50);
    n_vec++;
    if ({busy, cmd_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b_accept: busy/ready got %b want 10", {busy, cmd_ready});
    end
    collect(10);
    n_vec++;
    if (cap_adr.size() != 1 || cap_adr[0] != 2807 || cap_d[0] !== 24'hABCDEF) begin
      n_err++;
      $display("FAIL b2b_pixel: writes %0d adr %0d want 1 write adr 2807 d abcdef",
               cap_adr.size(), (cap_adr.size() > 0) ? cap_adr[0] : 0);
    end
  endtask

  task automatic test_range;
    send(2'b10, 9'd270, 8'd190, 9'd300, 8'd200, 24'h0F0F0F);
    collect(100);
`ifdef FB_DRAW_CLIP_EN
    n_vec++;
    if (cap_adr.size() != 20 || cap_errs != 0) begin
      n_err++;
      $display("FAIL clip_fill: writes/errs got %0d/%0d want 20/0", cap_adr.size(), cap_errs);
    end else begin
      n_vec++;
      if (cap_adr[0] != 53470 || cap_adr[19] != 53759) begin
        n_err++;
        $display("FAIL clip_ends: first/last got %0d/%0d want 53470/53759", cap_adr[0], cap_adr[19]);
      end
    end
`else
    n_vec++;
    if (cap_adr.size() != 0 || cap_errs != 1) begin
      n_err++;
      $display("FAIL oob_fill: writes/errs got %0d/%0d want 0/1", cap_adr.size(), cap_errs);
    end
`endif
    send(2'b01, 9'd280, 8'd0, 9'd0, 8'd0, 24'h111111);
    collect(20);
    n_vec++;
`ifdef FB_DRAW_CLIP_EN
    if (cap_adr.size() != 0 || cap_errs != 0) begin
      n_err++;
      $display("FAIL clip_pixel: writes/errs got %0d/%0d want 0/0", cap_adr.size(), cap_errs);
    end
`else
    if (cap_adr.size() != 0 || cap_errs != 1) begin
      n_err++;
      $display("FAIL oob_pixel: writes/errs got %0d/%0d want 0/1", cap_adr.size(), cap_errs);
    end
`endif
    send(2'b01, 9'd279, 8'd191, 9'd0, 8'd0, 24'h222222);
    collect(20);
    n_vec++;
    if (cap_adr.size() != 1 || cap_errs != 0 || cap_adr[0] != 53759) begin
      n_err++;
      $display("FAIL corner_pixel: writes/errs got %0d/%0d want 1/0 at adr 53759", cap_adr.size(), cap_errs);
    end
  endtask

  task automatic test_reset_mid;
    int wcount;
    send(2'b11, 9'd0, 8'd0, 9'd0, 8'd0, 24'h0000FF);
    wcount = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLOCK_50);
      if (fb_we) wcount++;
      if (wcount == 100) break;
    end
    n_vec++;
    if (wcount != 100) begin
      n_err++;
      $display("FAIL midreset_reach: writes got %0d want 100", wcount);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if ({fb_we, busy, cmd_ready} !== 3'b001 || fb_adr_w !== 16'd0) begin
      n_err++;
      $display("FAIL midreset_abort: we/busy/ready got %b adr %0d want 001 adr 0", {fb_we, busy, cmd_ready}, fb_adr_w);
    end
    @(negedge CLOCK_50);
    reset = 1'b1;
    send(2'b01, 9'd3, 8'd1, 9'd0, 8'd0, 24'h123456);
    collect(10);
    n_vec++;
    if (cap_adr.size() != 1 || cap_adr[0] != 283 || cap_d[0] !== 24'h123456) begin
      n_err++;
      $display("FAIL midreset_pixel: writes %0d want 1 write adr 283 d 123456", cap_adr.size());
    end
  endtask

  task automatic test_nop_stream;
    @(negedge CLOCK_50);
    cmd_op = 2'b00; cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLOCK_50);
      n_vec++;
      if (busy !== ((i % 2) == 0) || fb_we !== 1'b0 || cmd_err !== 1'b0) begin
        n_err++;
        $display("FAIL nop_cycle %0d: busy/we/err got %b%b%b want %b00", i, busy, fb_we, cmd_err, (i % 2) == 0);
      end
    end
    cmd_valid = 1'b0;
    @(negedge CLOCK_50);
    n_vec++;
    if ({busy, cmd_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL nop_idle: busy/ready got %b want 01", {busy, cmd_ready});
    end
  endtask

  initial begin
    test_reset();
    test_pixel();
    test_fill();
    test_back_to_back();
    test_range();
    test_reset_mid();
    test_nop_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
